seq_chunk_mult_ctrl: RTL
========================

Name: seq_chunk_mult_ctrl

Overview:
- Multi-cycle unsigned W×W multiplier controller. It sequences a single 3×3 combinational multiplier cell (three_bit_mult: 3-bit A, 3-bit B, 6-bit Y) over all 3-bit digit pairs of the operands.
- Each digit-pair partial product is shifted and accumulated into a 2W-bit result.
- Sits between a requesting datapath (start/done handshake) and the shared 3×3 multiplier cell. The cell is instantiated exactly once.

Parameters:
- W, 6, operand width in bits. Must be a multiple of 3 and ≥3; any other value is an elaboration error.
- D (localparam), W/3, number of 3-bit digits per operand.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  W  multiplicand; captured on the accepting edge
- b  in  W  multiplier; captured on the accepting edge
- busy  out  1  high while in BUSY
- done  out  1  one-cycle pulse; y valid while high
- y  out  2W  product; holds its value until the next accepted start

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset state: IDLE, busy=0, done=0, y=0, accumulator=0, digit counter=0, latched operands=0.
- States:
  - IDLE: start=1 → BUSY; latch a and b; acc=0; idx=0. Otherwise stay in IDLE.
  - BUSY: each cycle, i=idx mod D (a digit), j=idx/D (b digit). Compute pp = cell(a_l[3i+2:3i], b_l[3j+2:3j]), zero-extended to 2W bits. Then acc += pp << 3(i+j) and idx++. When idx==D*D-1: y <= acc+shifted pp, go to DONE.
  - DONE: one cycle, done=1. If start=1 → BUSY with a new capture (back-to-back). Otherwise → IDLE.
- busy and done are registered, decoded from state.
- Digit order: i is the inner index, j the outer index.
- Latency: done goes high D*D clock edges after the start-capture edge (4 for W=6). Throughput is one result per D*D+1 cycles back-to-back.
- Arithmetic: unsigned, no truncation. The 2W-bit accumulator cannot overflow because max product < 2^(2W).
- start while BUSY: ignored. The request is not queued, and operands are not re-latched.
- a and b changes after capture: no effect on the operation in flight.
- y is updated only on the DONE transition. It is stable during BUSY and shows the previous result.
- rst during BUSY or DONE: immediate abort to the reset state. No done pulse is produced, and y is cleared.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined: if the captured a==0 or b==0, IDLE/DONE go directly to DONE with y=0. done is then asserted one edge after the capture edge, and busy is never raised.
- Undefined: zero operands take the full D*D-cycle path and produce y=0.
- Handshake and reset behaviour are otherwise identical in both builds.

Test Plan:
- Reset release, then a=7, b=5, start pulse, W=6 → busy=1 for 4 cycles; done pulses 4 edges after capture; y=35; y holds 35 after done drops.
- a=63, b=63 → y=3969 (12'hF81). Then a=1, b=63 → y=63.
- Back-to-back: start held high with 6×6, then 2×3 presented during the DONE cycle → y=36 with done, then y=6 with done 4 edges later; no idle gap.
- Start pulsed with a=5, b=5 on the 2nd BUSY cycle of a 3×4 operation → y=12 only; no second done; busy drops after one done.
- rst asserted asynchronously on the 3rd BUSY cycle of 9×9 → busy=0, y=0 at once, no done. A new start with 2×2 → y=4.
- Zero bypass: 0×45 → with MULT_ZERO_BYPASS_EN, done 1 edge after capture and busy never high; without it, done after 4 edges; y=0 in both builds.

Source files
------------

// File: rtl/seq_chunk_mult_ctrl.sv
// Multi-cycle unsigned WxW multiplier that walks one shared 3x3 cell over all digit pairs.
// Optional build macro MULT_ZERO_BYPASS_EN: a zero operand skips straight to DONE with y=0.

module three_bit_mult (
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic [5:0] y_o
);
  assign y_o = a_i * b_i;
endmodule

module seq_chunk_mult_ctrl #(
  parameter int W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   y
);
  localparam int D  = W / 3;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int SW = $clog2(2 * W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

  generate
    if ((W % 3) != 0 || W < 3) begin : g_bad_width
      $error("seq_chunk_mult_ctrl: W must be a multiple of 3 and >= 3");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d, y_q, y_d;
  logic [CW-1:0]    i_q, i_d, j_q, j_d;
  logic             busy_q, done_q;

  logic [SW-1:0]    a_sh, b_sh, pp_sh_amt;
  logic [2:0]       a_dig, b_dig;
  logic [5:0]       pp;
  logic [2*W-1:0]   pp_sh;

  // i walks the multiplicand digits (inner), j the multiplier digits (outer).
  assign a_sh      = SW'(3) * SW'(i_q);
  assign b_sh      = SW'(3) * SW'(j_q);
  assign pp_sh_amt = SW'(3) * (SW'(i_q) + SW'(j_q));
  assign a_dig     = 3'(a_q >> a_sh);
  assign b_dig     = 3'(b_q >> b_sh);
  assign pp_sh     = (2*W)'(pp) << pp_sh_amt;

  three_bit_mult u_cell (
    .a_i (a_dig),
    .b_i (b_dig),
    .y_o (pp)
  );

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_BUSY;
`ifdef MULT_ZERO_BYPASS_EN
          if (a == '0 || b == '0) begin
            y_d     = '0;
            state_d = S_DONE;
          end
`else
`endif
        end
      end
      S_BUSY: begin
        acc_d = acc_q + pp_sh;
        if (i_q == LAST_DIGIT) begin
          i_d = '0;
          if (j_q == LAST_DIGIT) begin
            y_d     = acc_q + pp_sh;
            state_d = S_DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      y_q     <= y_d;
      busy_q  <= (state_d == S_BUSY);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule
